// File: rtl/shift_pkg.sv
// Shared definitions for the JK-cell universal shift register.
//   shift_mode_e : 3-bit operation select presented on the mode port
//   is_shift()   : true for the modes that advance the shift counter
package shift_pkg;

  typedef enum logic [2:0] {
    M_HOLD   = 3'd0,
    M_SHR    = 3'd1,
    M_SHL    = 3'd2,
    M_LOAD   = 3'd3,
    M_ROTR   = 3'd4,
    M_ROTL   = 3'd5,
    M_CLEAR  = 3'd6,
    M_INVERT = 3'd7
  } shift_mode_e;

  localparam int NUM_MODES = 8;

  // Shifts and rotates are the operations that count toward a frame.
  function automatic logic is_shift(shift_mode_e m);
    return (m == M_SHR) || (m == M_SHL) || (m == M_ROTR) || (m == M_ROTL);
  endfunction

endpackage

// File: rtl/jkff_cell.sv
// Single JK flip-flop, falling-edge clocked.
//   clk   : clock (state changes on the falling edge)
//   reset : synchronous active-high, forces q to 0
//   j, k  : 00 hold, 01 clear, 10 set, 11 toggle
//   q     : stored bit
module jkff_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(negedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_univ_shift_reg.sv
// Universal shift register built from WIDTH JK cells, falling-edge clocked.
//   clk, reset           : clock / synchronous active-high reset
//   mode                 : shift_mode_e operation, sampled every falling edge
//   ser_in_r / ser_in_l  : serial inputs entering q[WIDTH-1] (SHR) / q[0] (SHL)
//   par_in               : parallel load data
//   q                    : register contents
//   ser_out_r/ser_out_l  : q[0] / q[WIDTH-1], combinational
//   shift_cnt            : shifts since reset/LOAD/CLEAR, saturates at WIDTH
//   full                 : shift_cnt == WIDTH, registered
//   frame_done           : one-cycle pulse when shift_cnt reaches WIDTH
module jk_univ_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             full,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  shift_mode_e      w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  logic [CNT_W-1:0] r_cnt;
  logic             r_full;
  logic             r_frame_done;

  assign w_mode = shift_mode_e'(mode);

  // Next-state for data modes, then steering onto J/K. HOLD and INVERT
  // bypass the next-state value and use the cells' native hold/toggle.
  always_comb begin
    w_next = w_q;
    case (w_mode)
      M_SHR:   w_next = {ser_in_r, w_q[WIDTH-1:1]};
      M_SHL:   w_next = {w_q[WIDTH-2:0], ser_in_l};
      M_LOAD:  w_next = par_in;
      M_ROTR:  w_next = {w_q[0], w_q[WIDTH-1:1]};
      M_ROTL:  w_next = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
      M_CLEAR: w_next = '0;
      default: w_next = w_q;
    endcase

    w_j = w_next;
    w_k = ~w_next;
    case (w_mode)
      M_HOLD: begin
        w_j = '0;
        w_k = '0;
      end
      M_INVERT: begin
        w_j = '1;
        w_k = '1;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jkff_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .j    (w_j[g]),
      .k    (w_k[g]),
      .q    (w_q[g])
    );
  end

  // Frame counter. full and frame_done are registered alongside the count
  // so all three change on the same edge as q.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_full       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_mode == M_LOAD || w_mode == M_CLEAR) begin
        r_cnt  <= '0;
        r_full <= 1'b0;
      end else if (is_shift(w_mode) && r_cnt != CNT_MAX) begin
        r_cnt        <= r_cnt + CNT_ONE;
        r_full       <= (r_cnt == CNT_LAST);
        r_frame_done <= (r_cnt == CNT_LAST);
      end
    end
  end

  assign q          = w_q;
  assign ser_out_r  = w_q[0];
  assign ser_out_l  = w_q[WIDTH-1];
  assign shift_cnt  = r_cnt;
  assign full       = r_full;
  assign frame_done = r_frame_done;

endmodule
